// File: rtl/delay_sched.sv
// delay_sched -- round-robin owner arbitration for a single shared
// down-counting delay timer.
//
// Parameters
//   NREQ   number of requesters (2..16)
//   CBITS  counter width, 2**CBITS must exceed MAXD
//   MAXD   largest delay honoured; larger requests are clamped to MAXD
//
// Ports
//   clk    single clock, rising edge
//   rst    asynchronous reset, active low
//   req    per-requester request level, held until done (drop = abort)
//   dly    delay of requester i in dly[i*CBITS +: CBITS], sampled at grant
//   gnt    one-hot (or zero) ownership of the counter
//   done   one-cycle completion pulse to the owner
//   busy   counter currently owned
//   err    sticky: some granted delay exceeded MAXD
//
// Optional build macro
//   DELAY_SCHED_SVA_EN  compiles in concurrent assertions; no behavioural change
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | no owner, round-robin arbitration each cycle
// S_COUNT | owner holds counter, cnt counts down to 0
// S_DONE  | done[owner] and gnt[owner] high for one cycle

module delay_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 19,
    parameter int MAXD  = 400000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] MAXD_C = CBITS'(MAXD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CBITS-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;

    logic              found;
    logic [PW-1:0]     sel_idx;
    logic [PW-1:0]     idx;
    logic [CBITS-1:0]  sel_dly;
    logic              sel_over;

    // Round-robin pick: first requester found searching upward from ptr+1.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found   = 1'b1;
                sel_idx = idx;
            end
        end
    end

    assign sel_dly  = dly[sel_idx*CBITS +: CBITS];
    assign sel_over = (sel_dly > MAXD_C);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (found) begin
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                    cnt_d   = sel_over ? MAXD_C : sel_dly;
                    ptr_d   = sel_idx;
                    err_d   = err_q | sel_over;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // Abort wins over completion, even when cnt has reached 0.
                if (!req[ptr_q]) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CBITS'(1);
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

`ifdef DELAY_SCHED_SVA_EN
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(gnt));
    a_done_has_gnt: assert property (@(posedge clk) disable iff (!rst)
        ((done & ~gnt) == '0));
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst)
        (|done) |=> !(|done));
    a_done_then_idle: assert property (@(posedge clk) disable iff (!rst)
        (|done) |=> !busy);
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_live
        // A requester that keeps req high is eventually served; dropping
        // req is an abort and discharges the obligation.
        a_live: assert property (@(posedge clk) disable iff (!rst)
            req[gi] |-> s_eventually (done[gi] || !req[gi]));
    end
`endif

endmodule

// File: tb/tb_delay_sched.sv
module tb_delay_sched;

    localparam int NREQ  = 4;
    localparam int CBITS = 5;
    localparam int MAXD  = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CBITS-1:0] dly = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: who owns the timer, how many edges since its grant,
    // the effective delay, the round-robin pointer and the sticky error.
    int m_owner;
    int m_age;
    int m_d;
    int m_ptr;
    bit m_err;

    int done_at, idle_at, saw3;
    int g_order[5];
    int g_time[5];
    int ng;
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] ed;

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .MAXD(MAXD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dly  (dly),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] r;
        r = '0;
        if (m_owner >= 0) r[m_owner] = 1'b1;
        return r;
    endfunction

    function automatic logic [NREQ-1:0] exp_done();
        logic [NREQ-1:0] r;
        r = '0;
        if (m_owner >= 0 && m_age == m_d + 1) r[m_owner] = 1'b1;
        return r;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_d     = 0;
        m_ptr   = NREQ - 1;
        m_err   = 1'b0;
    endtask

    // One clock edge of the timing rules: owner keeps the timer for d+2
    // cycles (grant, d+1 counting edges, one done cycle) unless req drops
    // while counting; a free timer goes to the next requester after ptr.
    task automatic model_step();
        int v;
        bit found;
        if (m_owner >= 0) begin
            if (m_age <= m_d) begin
                if (!req[m_owner]) m_owner = -1;
                else m_age++;
            end else begin
                m_owner = -1;
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    v       = int'(dly[c*CBITS +: CBITS]);
                    m_owner = c;
                    m_ptr   = c;
                    m_age   = 0;
                    m_d     = (v > MAXD) ? MAXD : v;
                    if (v > MAXD) m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("gnt",  32'(gnt),  32'(exp_gnt()));
        chk("done", 32'(done), 32'(exp_done()));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("err",  32'(err),  32'(m_err));
    endtask

    // Asserts reset between edges and checks the outputs clear before any
    // clock edge; releases it at a falling edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_dly(input int i, input int v);
        dly[i*CBITS +: CBITS] = CBITS'(v);
    endtask

    initial begin
        model_reset();

        // Single request, d=5.
        do_reset();
        set_dly(2, 5);
        req = 4'b0100;
        tick();
        chk("t1_gnt", 32'(gnt), 32'b0100);
        done_at = -1;
        idle_at = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (done[2] && done_at < 0) done_at = c;
            if (!busy && idle_at < 0) idle_at = c;
            if (done[2]) req = '0;
        end
        chk("t1_done_lat", 32'(done_at), 32'd6);
        chk("t1_busy_lat", 32'(idle_at), 32'd7);

        // All requesting with zero delay: rotating grants, 3 cycles apart.
        req = '0;
        do_reset();
        dly = '0;
        req = 4'b1111;
        ng = 0;
        prev_gnt = '0;
        for (int j = 0; j < 5; j++) begin g_order[j] = -1; g_time[j] = -1; end
        for (int c = 0; c < 16; c++) begin
            tick();
            if (gnt != '0 && prev_gnt == '0 && ng < 5) begin
                g_order[ng] = onehot_idx(gnt);
                g_time[ng]  = c;
                ng++;
            end
            prev_gnt = gnt;
        end
        chk("t2_ngrants", 32'(ng), 32'd5);
        for (int j = 0; j < 5; j++) chk("t2_order", 32'(g_order[j]), 32'(j % NREQ));
        for (int j = 1; j < 5; j++) chk("t2_spacing", 32'(g_time[j] - g_time[j-1]), 32'd3);

        // Over-range delay is clamped and sets the sticky error.
        req = '0;
        do_reset();
        set_dly(1, 15);
        req = 4'b0010;
        tick();
        chk("t3_gnt", 32'(gnt), 32'b0010);
        chk("t3_err_at_grant", 32'(err), 32'd1);
        done_at = -1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (done[1] && done_at < 0) done_at = c;
            if (done[1]) req = '0;
        end
        chk("t3_done_lat", 32'(done_at), 32'(MAXD + 1));
        set_dly(0, 2);
        req = 4'b0001;
        done_at = -1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done[0] && done_at < 0) done_at = c;
            if (done[0]) req = '0;
        end
        chk("t3_clean_done", 32'(done_at), 32'd3);
        chk("t3_err_sticky", 32'(err), 32'd1);

        // Abort: owner drops req mid-count, pending requester takes over.
        req = '0;
        do_reset();
        set_dly(3, 8);
        set_dly(0, 1);
        req = 4'b1000;
        saw3 = 0;
        tick();
        chk("t4_gnt", 32'(gnt), 32'b1000);
        req[0] = 1'b1;
        tick();
        tick();
        req[3] = 1'b0;
        tick();
        chk("t4_abort_gnt", 32'(gnt), 32'd0);
        tick();
        chk("t4_next_gnt", 32'(gnt), 32'b0001);
        for (int c = 0; c < 12; c++) begin
            if (done[3]) saw3++;
            tick();
            if (done[0]) req[0] = 1'b0;
        end
        chk("t4_no_done3", 32'(saw3), 32'd0);

        // Reset in the middle of a count; requester 0 wins first after release.
        req = '0;
        do_reset();
        set_dly(1, 20);
        set_dly(0, 3);
        req = 4'b0010;
        tick();
        chk("t5_gnt", 32'(gnt), 32'b0010);
        req = 4'b0011;
        for (int c = 0; c < 4; c++) tick();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        do_reset();
        tick();
        chk("t5_rr_after_reset", 32'(gnt), 32'b0001);

        // Randomized traffic with aborts and changing delays.
        req = '0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ed = exp_done();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (ed[i]) req[i] = ($urandom % 2) == 1;
                    else if ($urandom % 40 == 0) req[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    req[i] = 1'b1;
                end
                if ($urandom % 4 == 0) set_dly(i, int'($urandom_range(15, 0)));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
